// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 master bridge.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // pprot bit masks
  localparam logic [2:0] PPROT_PRIV      = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE = 3'b010;
  localparam logic [2:0] PPROT_INSTR     = 3'b100;

endpackage

// File: rtl/apb4_timeout_cnt.sv
// ACCESS-phase wait counter; expired is high during the last permitted ACCESS cycle.
module apb4_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_tie;
      assign unused_tie = ^{clk, rst, clr, en};
      assign expired    = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYCLES + 1);
      // counter holds the number of ACCESS cycles already spent without pready
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);
      logic [W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else if (en)    cnt_q <= cnt_q + 1'b1;
      end

      assign expired = (cnt_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb4_master_bridge.sv
// Native valid/ready request port to APB4 master, one outstanding transfer, bounded wait.
module apb4_master_bridge
  import apb4_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                        req_we_i,
  input  logic [APB_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [2:0]                  req_prot_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]                  pprot,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb,
  input  logic                        pready,
  input  logic [APB_DATA_WIDTH-1:0]   prdata,
  input  logic                        pslverr
);

  apb_state_e state_q, state_d;
  logic       accept, expired;

  assign accept      = (state_q == IDLE) && req_valid_i;
  assign req_ready_o = (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);

  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || expired) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  apb4_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (pclk),
    .rst     (preset),
    .clr     (state_q != ACCESS),
    .en      ((state_q == ACCESS) && !pready),
    .expired (expired)
  );

  // APB-side request latch; only loads on accept so the bus holds between transfers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr  <= '0;
      pprot  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      paddr  <= req_addr_i;
      pprot  <= req_prot_i;
      pwrite <= req_we_i;
      pwdata <= req_wdata_i;
      pstrb  <= req_we_i ? req_wstrb_i : '0;
    end
  end

  // pready is checked first so a completion on the expiry cycle is not reported as a timeout.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state_q == ACCESS) begin
      if (pready) begin
        rsp_err_o   <= pslverr;
        rsp_rdata_o <= (!pwrite && !pslverr) ? prdata : '0;
      end else if (expired) begin
        rsp_err_o   <= 1'b1;
        rsp_rdata_o <= '0;
      end
    end
  end

endmodule
